// File: rtl/vi_button_event_pkg.sv
// vi_button_event_pkg: shared state encoding and saturation helpers for the button event stage
//
// Contents:
//   state_t  - FSM encoding shared by vi_button_event (IDLE, PRESSED, LONG)
//   SAT_W    - widest counter the saturation helper handles
//   sat_max  - all-ones value of a w-bit counter, used as the saturation ceiling
package vi_button_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam int SAT_W = 32;

  // For w == 32 the shift wraps to zero, so the subtraction still yields all ones.
  function automatic logic [SAT_W-1:0] sat_max(input int w);
    return (SAT_W'(1) << w) - SAT_W'(1);
  endfunction

endpackage

// File: rtl/vi_sat_counter.sv
// vi_sat_counter: parameterised up-counter with sync clear, load and saturation
//
// Parameters:
//   W         counter width
// Ports:
//   clk       clock
//   reset     synchronous active-high reset, clears q
//   clr       synchronous clear, beats load and inc
//   load      loads load_val, beats inc
//   load_val  value to load
//   inc       increments q, holding at 2^W-1
//   q         counter value
module vi_sat_counter
  import vi_button_event_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  always_ff @(posedge clk)
    if (reset || clr) q <= '0;
    else if (load) q <= load_val;
    else if (inc && q != MAX) q <= q + 1'b1;

endmodule

// File: rtl/vi_button_event.sv
// vi_button_event: turns a debounced level into press/release pulses, press count, hold time and long-press events
//
// Build option: VI_LONG_PRESS_EN enables the LONG state, long_press and held;
// without it long_press and held are tied low and LONG_CYCLES is only range-checked.
//
// Parameters:
//   LONG_CYCLES  hold length in cycles that qualifies as a long press (2 .. 2^HOLD_W-1)
//   HOLD_W       width of the hold timer and hold_time
//   CNT_W        width of press_count
// Ports:
//   clk          clock
//   reset        synchronous active-high reset, overrides everything
//   debounced    debounced level, synchronous to clk
//   count_clr    clears press_count (a same-cycle rise still counts)
//   level        registered copy of debounced
//   rise_pulse   one-cycle pulse on press
//   fall_pulse   one-cycle pulse on release
//   hold_time    length of the last completed press in cycles, saturated
//   hold_valid   one-cycle pulse when hold_time updates
//   press_count  wrapping press counter
//   long_press   one-cycle pulse when a hold reaches LONG_CYCLES
//   held         high while a long press is in progress
module vi_button_event
  import vi_button_event_pkg::*;
#(
  parameter int LONG_CYCLES = 1000,
  parameter int HOLD_W      = 24,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debounced,
  input  logic              count_clr,
  output logic              level,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [HOLD_W-1:0] hold_time,
  output logic              hold_valid,
  output logic [CNT_W-1:0]  press_count,
  output logic              long_press,
  output logic              held
);

  if (LONG_CYCLES < 2 || LONG_CYCLES > sat_max(HOLD_W)) begin : g_bad_long_cycles
    $error("vi_button_event: LONG_CYCLES out of range for HOLD_W");
  end

  logic              d_q;
  logic              rise;
  logic              fall;
  logic [HOLD_W-1:0] timer;
  state_t            state;

  assign rise  = debounced & ~d_q;
  assign fall  = ~debounced & d_q;
  assign level = d_q;

  // Timer counts sampled-high edges: loads 1 on the rise edge, clears on release
  // so it sits at 0 in IDLE.
  vi_sat_counter #(.W(HOLD_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (fall),
    .load     (rise),
    .load_val (HOLD_W'(1)),
    .inc      (debounced && state != IDLE),
    .q        (timer)
  );

`ifdef VI_LONG_PRESS_EN
  localparam logic [HOLD_W-1:0] LONG_M1 = HOLD_W'(LONG_CYCLES - 1);

  // The long event fires on the edge where the timer steps from LONG_CYCLES-1 to
  // LONG_CYCLES; a release on that edge has debounced=0 and so wins.
  always_ff @(posedge clk)
    if (reset) begin
      d_q         <= 1'b0;
      state       <= IDLE;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      hold_valid  <= 1'b0;
      hold_time   <= '0;
      press_count <= '0;
      long_press  <= 1'b0;
      held        <= 1'b0;
    end else begin
      d_q         <= debounced;
      rise_pulse  <= rise;
      fall_pulse  <= fall;
      hold_valid  <= fall;
      hold_time   <= fall ? timer : hold_time;
      press_count <= count_clr ? CNT_W'(rise) : press_count + CNT_W'(rise);
      long_press  <= 1'b0;
      case (state)
        IDLE:    state <= rise ? PRESSED : IDLE;
        PRESSED:
          if (fall) state <= IDLE;
          else if (debounced && timer == LONG_M1) begin
            state      <= LONG;
            long_press <= 1'b1;
            held       <= 1'b1;
          end
        LONG:
          if (fall) begin
            state <= IDLE;
            held  <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
`else
  assign long_press = 1'b0;
  assign held       = 1'b0;

  always_ff @(posedge clk)
    if (reset) begin
      d_q         <= 1'b0;
      state       <= IDLE;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      hold_valid  <= 1'b0;
      hold_time   <= '0;
      press_count <= '0;
    end else begin
      d_q         <= debounced;
      rise_pulse  <= rise;
      fall_pulse  <= fall;
      hold_valid  <= fall;
      hold_time   <= fall ? timer : hold_time;
      press_count <= count_clr ? CNT_W'(rise) : press_count + CNT_W'(rise);
      state       <= rise ? PRESSED : fall ? IDLE : state;
    end
`endif

endmodule

// File: tb/tb_vi_button_event.sv
// tb_vi_button_event: table-driven check of vi_button_event with hand-computed expectations
module tb_vi_button_event;

  localparam int L = 8, HW = 4, CW = 2;
`ifdef VI_LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1, debounced = 1'b0, count_clr = 1'b0;
  logic          level, rise_pulse, fall_pulse, hold_valid, long_press, held;
  logic [HW-1:0] hold_time;
  logic [CW-1:0] press_count;

  vi_button_event #(.LONG_CYCLES(L), .HOLD_W(HW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .debounced   (debounced),
    .count_clr   (count_clr),
    .level       (level),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .hold_time   (hold_time),
    .hold_valid  (hold_valid),
    .press_count (press_count),
    .long_press  (long_press),
    .held        (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        d, c, r;
    logic [11:0] e;
  } vec_t;

  vec_t vq[$];
  int   runs = 0, fails = 0;

  // Expected output word {level, rise, fall, hold_valid, hold_time, press_count, long_press, held}.
  function automatic logic [11:0] pk(logic lv, logic ri, logic fa, logic hv, int ht, int pc, logic lg, logic h);
    return {lv, ri, fa, hv, 4'(ht), 2'(pc), lg & LP, h & LP};
  endfunction

  task automatic add(logic d, logic c, logic r, logic [11:0] e);
    vq.push_back('{d: d, c: c, r: r, e: e});
  endtask

  // n sampled-high edges then one low edge; timer equals i after high edge i.
  task automatic press(int n, int pc, int ht0);
    for (int i = 1; i <= n; i++) add(1, 0, 0, pk(1, i == 1, 0, 0, ht0, pc, i == L, i >= L));
    add(0, 0, 0, pk(0, 0, 1, 1, n > 15 ? 15 : n, pc, 0, 0));
  endtask

  task automatic idle(int pc, int ht);
    add(0, 0, 0, pk(0, 0, 0, 0, ht, pc, 0, 0));
  endtask

  task automatic step(logic d, logic c, logic r);
    @(negedge clk);
    debounced = d;
    count_clr = c;
    reset     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [11:0] e);
    logic [11:0] a;
    a = {level, rise_pulse, fall_pulse, hold_valid, hold_time, press_count, long_press, held};
    runs++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b required %b (lvl rise fall hv ht pc long held)", nm, a, e);
    end
  endtask

  initial begin
    repeat (3) add(0, 0, 1, 12'd0);
    repeat (4) idle(0, 0);
    press(3, 1, 0);
    idle(1, 3);
    press(8, 2, 3);
    idle(2, 8);
    press(20, 3, 8);
    idle(3, 15);
    add(0, 1, 0, pk(0, 0, 0, 0, 15, 0, 0, 0));
    press(1, 1, 15);
    press(1, 2, 1);
    press(1, 3, 1);
    press(1, 0, 1);
    press(1, 1, 1);
    press(1, 2, 1);
    add(1, 1, 0, pk(1, 1, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, pk(0, 0, 1, 1, 1, 1, 0, 0));
    press(7, 2, 1);
    idle(2, 7);

    foreach (vq[k]) begin
      step(vq[k].d, vq[k].c, vq[k].r);
      chk($sformatf("vec%0d", k), vq[k].e);
    end

    for (int i = 1; i <= 9; i++) begin
      step(1, 0, 0);
      chk($sformatf("long_hold%0d", i), pk(1, i == 1, 0, 0, 7, 3, i == L, i >= L));
    end
    step(1, 0, 1);
    chk("reset_in_long0", 12'd0);
    step(1, 0, 1);
    chk("reset_in_long1", 12'd0);
    step(1, 0, 0);
    chk("rise_after_reset", pk(1, 1, 0, 0, 0, 1, 0, 0));
    step(0, 0, 0);
    chk("fall_after_reset", pk(0, 0, 1, 1, 1, 1, 0, 0));

    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
